// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller: power-up delay, fixed init
// sequence, then one timed SETUP/PULSE/HOLD/WAIT write per accepted command.
module lcd_ctrl #(
  parameter int unsigned POWERON_CYC  = 750000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  input  logic       lcd_on_in,
  output logic       lcd_on,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    WAIT  = 3'd5
  } state_t;

  localparam logic [31:0] PWR_LAST   = 32'(POWERON_CYC - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_CYC - 1);

  state_t      state_r, state_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic [1:0]  idx_r, idx_nxt_s;
  logic        init_done_r, init_done_nxt_s;
  logic        rs_r, rs_nxt_s;
  logic [7:0]  data_r, data_nxt_s;
  logic        cmd_ready_r, cmd_ready_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        en_r, en_nxt_s;
  logic        lcd_on_r;
  logic [31:0] wait_last_s;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Clear and return-home instructions need the long execution wait.
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  assign wait_last_s = is_clear_cmd(rs_r, data_r) ? CLR_LAST : WAIT_LAST;

  // Next-state, counter, init index and latched command byte.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    init_done_nxt_s = init_done_r;
    rs_nxt_s        = rs_r;
    data_nxt_s      = data_r;
    case (state_r)
      PWRUP: begin
        if (cnt_r == PWR_LAST) begin
          state_nxt_s = SETUP;
          cnt_nxt_s   = 32'd0;
          rs_nxt_s    = 1'b0;
          data_nxt_s  = init_byte(idx_r);
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_nxt_s = SETUP;
          cnt_nxt_s   = 32'd0;
          rs_nxt_s    = cmd_rs;
          data_nxt_s  = cmd_data;
        end else begin
          cnt_nxt_s = 32'd0;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_nxt_s = PULSE;
          cnt_nxt_s   = 32'd0;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      PULSE: begin
        if (cnt_r == EN_LAST) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = 32'd0;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = 32'd0;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      WAIT: begin
        if (cnt_r == wait_last_s) begin
          cnt_nxt_s = 32'd0;
          if (init_done_r) begin
            state_nxt_s = IDLE;
          end else if (idx_r == 2'd3) begin
            state_nxt_s     = IDLE;
            init_done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = SETUP;
            idx_nxt_s   = idx_r + 2'd1;
            rs_nxt_s    = 1'b0;
            data_nxt_s  = init_byte(idx_r + 2'd1);
          end
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_nxt_s = PWRUP;
        cnt_nxt_s   = 32'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register glitch-free.
  always_comb begin
    cmd_ready_nxt_s = (state_nxt_s == IDLE) && init_done_nxt_s;
    busy_nxt_s      = ~cmd_ready_nxt_s;
    en_nxt_s        = (state_nxt_s == PULSE);
  end

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PWRUP;
      cnt_r       <= 32'd0;
      idx_r       <= 2'd0;
      init_done_r <= 1'b0;
      rs_r        <= 1'b0;
      data_r      <= 8'h00;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b1;
      en_r        <= 1'b0;
      lcd_on_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      init_done_r <= init_done_nxt_s;
      rs_r        <= rs_nxt_s;
      data_r      <= data_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      en_r        <= en_nxt_s;
      lcd_on_r    <= lcd_on_in;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign lcd_en    = en_r;
  assign lcd_rs    = rs_r;
  assign lcd_data  = data_r;
  assign lcd_rw    = 1'b0;
  assign lcd_on    = lcd_on_r;

endmodule
